ram8_sweep: RTL and testbench
=============================

Name: ram8_sweep

Overview:
- 8-word register file that sits directly downstream of the 8-way demultiplexer stage.
- The demux decodes `load` by `address` into a one-hot word enable, and this block stores `in` into the selected word.
- Adds a registered read port, a write acknowledge, and a hardware clear-sweep state machine that zeroes all eight words, one per cycle.
- Used as the RAM8 building block for larger memory banks.

Parameters:
- WIDTH, 16, data width of each stored word and of `in`/`out`.

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in  input  WIDTH  write data
- load  input  1  write request for word[address]
- address  input  3  word select for read and write
- clear  input  1  request to start a clear sweep (sampled, level)
- out  output  WIDTH  registered read data
- busy  output  1  high while the clear sweep runs
- wr_ack  output  1  one-cycle pulse acknowledging an accepted write

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - all 8 words = 0
  - out = 0, busy = 0, wr_ack = 0
  - sweep counter = 0, state = IDLE
- Write decode: `load` is routed 8-way by `address` (one-hot enable, address 0 -> word0 ... 7 -> word7).
  - A write is accepted when state=IDLE and load=1.
  - word[address] <= in on that edge.
- wr_ack: registered; equals 1 in the cycle after an accepted write, otherwise 0. Back-to-back writes give back-to-back acks.
- Read: out <= word[address] every cycle, giving 1-cycle latency.
  - Read-during-write to the same address is write-first: out <= in.
- States: IDLE, SWEEP.
  - IDLE -> SWEEP when clear=1: counter <= 0, busy <= 1 on the same edge.
  - In SWEEP, each edge: word[counter] <= 0, counter <= counter+1.
  - Exit: on the edge that zeroes word7, state <= IDLE, busy <= 0, counter <= 0.
  - The sweep takes exactly 8 cycles with busy high.
- During SWEEP:
  - load is ignored: no write, no wr_ack.
  - clear is ignored: no restart.
  - Reads continue: out <= word[address] as currently held, so words show progressively zeroed values.
- Simultaneous load and clear in IDLE: the write is accepted and acked on that edge, the sweep starts on the same edge, and the written word is zeroed later by the sweep.
- clear held high continuously: a new sweep starts on the first IDLE cycle after each sweep ends.
- Counter is 3 bits; wrap 7->0 coincides with the return to IDLE.
- Reset asserted mid-sweep: immediate return to IDLE with all words zero; an in-flight wr_ack is cleared.

Test Plan:
- Reset, then write in=16'hA5A5 at address 3 with load=1 for one cycle -> wr_ack=1 next cycle. Then read address 3 -> out=16'hA5A5 one cycle after the address is applied; address 2 -> out=0.
- Write 16'h0001..16'h0008 to addresses 0..7 on consecutive cycles -> 8 consecutive wr_ack pulses. Sequential reads return the same values, each with 1-cycle latency.
- Write 16'h1234 at address 5 while address=5 -> out=16'h1234 on the very next cycle (write-first).
- With all words non-zero, pulse clear -> busy high for exactly 8 cycles. A load=1 at address 0 with in=16'hFFFF during busy gives no wr_ack. Afterwards all 8 words read 0.
- Assert load (address 6, in=16'hBEEF) and clear in the same IDLE cycle -> wr_ack=1, busy=1. After the sweep, address 6 reads 0.
- Start a sweep, drop reset_n after 3 cycles -> busy=0, out=0, wr_ack=0 immediately. After release, all words read 0 and a new write at address 1 is accepted.

Source files
------------

// File: rtl/ram8_sweep.sv
// RAM8 register file: one-hot decoded writes, registered read port, write ack,
// and a clear-sweep FSM that zeroes one word per cycle.
module ram8_sweep #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             wr_ack
);

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_next;
  logic [AW-1:0]    count, count_next;
  logic             wr_en_c;
  logic [DEPTH-1:0] word_en_c;
  logic [DEPTH-1:0] word_clr_c;
  logic [WIDTH-1:0] mem [DEPTH];

  // State and sweep counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next state, write decode and sweep clear select
  always_comb begin
    state_next = state;
    count_next = count;
    wr_en_c    = 1'b0;
    word_en_c  = '0;
    word_clr_c = '0;
    case (state)
      IDLE: begin
        wr_en_c = load;
        if (load) word_en_c[address] = 1'b1;
        if (clear) begin
          state_next = SWEEP;
          count_next = '0;
        end
      end
      SWEEP: begin
        word_clr_c[count] = 1'b1;
        count_next        = count + AW'(1);
        if (count == AW'(DEPTH - 1)) begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage words; sweep clear and write never coincide on a word
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)          mem[g] <= '0;
      else if (word_clr_c[g]) mem[g] <= '0;
      else if (word_en_c[g])  mem[g] <= in;
    end
  end

  // Registered outputs; read-during-write returns the new data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out    <= '0;
      busy   <= 1'b0;
      wr_ack <= 1'b0;
    end else begin
      out    <= wr_en_c ? in : mem[address];
      busy   <= (state_next == SWEEP);
      wr_ack <= wr_en_c;
    end
  end

endmodule

// File: tb/tb_ram8_sweep.sv
// Self-checking bench for ram8_sweep: behavioural model feeds a scoreboard
// queue of expected {out, busy, wr_ack} per clock.
module tb_ram8_sweep;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;
  logic        wr_ack;

  int checks = 0;
  int errors = 0;

  logic [17:0] sb [$];
  logic [15:0] mem_m [8];
  bit          sweep_m;
  int          cnt_m;

  ram8_sweep #(.WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .in(in), .load(load),
    .address(address), .clear(clear), .out(out), .busy(busy), .wr_ack(wr_ack)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    sweep_m = 0;
    cnt_m   = 0;
  endtask

  // Drive one cycle, push the model's expectation, return the DUT sample
  task automatic step(input logic ld, input logic [2:0] a, input logic [15:0] d,
                      input logic clr, output logic [17:0] obs);
    logic [15:0] e_out;
    logic        e_ack;
    load = ld; address = a; in = d; clear = clr;
    e_ack = !sweep_m && ld;
    e_out = e_ack ? d : mem_m[a];
    if (!sweep_m) begin
      if (ld) mem_m[a] = d;
      if (clr) begin sweep_m = 1; cnt_m = 0; end
    end else begin
      mem_m[cnt_m] = '0;
      if (cnt_m == 7) begin sweep_m = 0; cnt_m = 0; end
      else cnt_m++;
    end
    sb.push_back({e_out, 1'(sweep_m), e_ack});
    @(posedge clock); #1;
    obs = {out, busy, wr_ack};
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load = 0; clear = 0; address = '0; in = '0;
    model_reset();
    #12;
    checks++;
    if ({out, busy, wr_ack} !== 18'h0) begin
      errors++; $display("FAIL reset got %h want %h", {out, busy, wr_ack}, 18'h0);
    end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [17:0] obs, e;
    step(1, 3'd3, 16'hA5A5, 0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e || obs[0] !== 1'b1) begin errors++; $display("FAIL wr_a5 got %h want %h", obs, e); end
    step(0, 3'd3, 16'h0, 0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e || obs[17:2] !== 16'hA5A5) begin errors++; $display("FAIL rd3 got %h want %h", obs, e); end
    step(0, 3'd2, 16'h0, 0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e || obs[17:2] !== 16'h0) begin errors++; $display("FAIL rd2 got %h want %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] obs, e;
    for (int i = 0; i < 8; i++) begin
      step(1, 3'(i), 16'(i + 1), 0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e || obs[0] !== 1'b1) begin errors++; $display("FAIL b2b_wr%0d got %h want %h", i, obs, e); end
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 3'(i), 16'h0, 0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e || obs[17:2] !== 16'(i + 1)) begin errors++; $display("FAIL b2b_rd%0d got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_write_first();
    logic [17:0] obs, e;
    step(1, 3'd5, 16'h1234, 0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e || obs[17:2] !== 16'h1234) begin errors++; $display("FAIL wr_first got %h want %h", obs, e); end
  endtask

  task automatic test_sweep();
    logic [17:0] obs, e;
    int busy_cnt = 0;
    step(0, 3'd0, 16'h0, 1, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL sweep_start got %h want %h", obs, e); end
    busy_cnt += int'(obs[1]);
    for (int i = 0; i < 8; i++) begin
      step(i == 2, 3'd0, 16'hFFFF, 0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sweep_cyc%0d got %h want %h", i, obs, e); end
      busy_cnt += int'(obs[1]);
    end
    checks++;
    if (busy_cnt != 8) begin errors++; $display("FAIL sweep_len got %0d want 8", busy_cnt); end
    for (int i = 0; i < 8; i++) begin
      step(0, 3'(i), 16'h0, 0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e || obs[17:2] !== 16'h0) begin errors++; $display("FAIL swept_rd%0d got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_load_clear();
    logic [17:0] obs, e;
    step(1, 3'd6, 16'hBEEF, 1, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e || obs[1:0] !== 2'b11) begin errors++; $display("FAIL ld_clr got %h want %h", obs, e); end
    for (int i = 0; i < 8; i++) begin
      step(0, 3'd6, 16'h0, 0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL ld_clr_sw%0d got %h want %h", i, obs, e); end
    end
    step(0, 3'd6, 16'h0, 0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e || obs[17:2] !== 16'h0) begin errors++; $display("FAIL ld_clr_rd6 got %h want %h", obs, e); end
  endtask

  task automatic test_clear_held();
    logic [17:0] obs, e;
    int idle_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 3'(i + 2), 16'h5000 + 16'(i), 0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL held_pre%0d got %h want %h", i, obs, e); end
    end
    for (int i = 0; i < 18; i++) begin
      step(0, 3'(i), 16'h0, 1, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL held_cyc%0d got %h want %h", i, obs, e); end
      idle_cnt += int'(!obs[1]);
    end
    checks++;
    if (idle_cnt != 2) begin errors++; $display("FAIL held_gaps got %0d want 2", idle_cnt); end
    clear = 0;
  endtask

  task automatic test_reset_midsweep();
    logic [17:0] obs, e;
    step(1, 3'd4, 16'h7777, 0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mid_pre got %h want %h", obs, e); end
    step(0, 3'd4, 16'h0, 1, obs);
    e = sb.pop_front();
    for (int i = 0; i < 2; i++) begin
      step(0, 3'd4, 16'h0, 0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e || obs[1] !== 1'b1) begin errors++; $display("FAIL mid_sw%0d got %h want %h", i, obs, e); end
    end
    reset_n = 1'b0; model_reset();
    #1; checks++;
    if ({out, busy, wr_ack} !== 18'h0) begin
      errors++; $display("FAIL mid_rst got %h want %h", {out, busy, wr_ack}, 18'h0);
    end
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 3'(i), 16'h0, 0, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e || obs[17:2] !== 16'h0) begin errors++; $display("FAIL mid_rd%0d got %h want %h", i, obs, e); end
    end
    step(1, 3'd1, 16'hC0DE, 0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e || obs[0] !== 1'b1) begin errors++; $display("FAIL mid_wr got %h want %h", obs, e); end
  endtask

  task automatic test_ack_reset();
    logic [17:0] obs, e;
    step(1, 3'd2, 16'h2222, 0, obs);
    e = sb.pop_front(); checks++;
    if (obs !== e || obs[0] !== 1'b1) begin errors++; $display("FAIL ackr_wr got %h want %h", obs, e); end
    reset_n = 1'b0; model_reset();
    #1; checks++;
    if (wr_ack !== 1'b0 || out !== 16'h0) begin
      errors++; $display("FAIL ackr_rst got %h want %h", {out, busy, wr_ack}, 18'h0);
    end
    load = 0;
    @(negedge clock); reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_write_first();
    test_sweep();
    test_load_clear();
    test_clear_held();
    test_reset_midsweep();
    test_ack_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
